// File: rtl/dsp_decode_if.sv
// Fetch-to-decode bus for dsp_decode: the instruction/PC from fetch, the
// flush and backpressure controls, and the registered decoded bundle that
// goes on to execute.
interface dsp_decode_if #(
  parameter int INST_WORD_LEN = 32,
  parameter int MEM_ADDR_LEN  = 16
) ();

  logic [INST_WORD_LEN-1:0] instruction_in;
  logic [MEM_ADDR_LEN-1:0]  pc_in;
  logic                     flush;
  logic                     stall_in;

  logic                     hold_out;
  logic                     valid_out;
  logic [5:0]               opcode_out;
  logic [4:0]               rd_out;
  logic [4:0]               rs1_out;
  logic [4:0]               rs2_out;
  logic [MEM_ADDR_LEN-1:0]  imm_out;
  logic [MEM_ADDR_LEN-1:0]  pc_out;
  logic                     reg_write_out;
  logic                     is_branch_out;
  logic                     illegal_out;
  logic                     halt_out;

  // Pipeline side: supplies instructions and consumes the decoded bundle.
  modport master (
    output instruction_in, pc_in, flush, stall_in,
    input  hold_out, valid_out, opcode_out, rd_out, rs1_out, rs2_out,
           imm_out, pc_out, reg_write_out, is_branch_out, illegal_out,
           halt_out
  );

  // Decoder side.
  modport slave (
    input  instruction_in, pc_in, flush, stall_in,
    output hold_out, valid_out, opcode_out, rd_out, rs1_out, rs2_out,
           imm_out, pc_out, reg_write_out, is_branch_out, illegal_out,
           halt_out
  );

endinterface

// File: rtl/dsp_decode.sv
// Decode stage of the DSP pipeline. Splits the instruction word into its
// fields, classifies the opcode, inserts a single bubble for a load-use
// dependency on the instruction currently in the output register, honours
// flush and execute backpressure, and parks in HALTED after issuing HALT.
module dsp_decode #(
  parameter int INST_WORD_LEN = 32,
  parameter int MEM_ADDR_LEN  = 16
) (
  input logic         clk,
  input logic         rst,
  dsp_decode_if.slave dec
);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_MUL  = 6'h03;
  localparam logic [5:0] OP_MAC  = 6'h04;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_ST   = 6'h09;
  localparam logic [5:0] OP_JMP  = 6'h10;
  localparam logic [5:0] OP_BEQ  = 6'h11;
  localparam logic [5:0] OP_BNE  = 6'h12;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HAZARD = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Everything that leaves the stage in one register; all-zero is a bubble.
  typedef struct packed {
    logic                    valid;
    logic [5:0]              opcode;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [MEM_ADDR_LEN-1:0] imm;
    logic [MEM_ADDR_LEN-1:0] pc;
    logic                    reg_write;
    logic                    is_branch;
    logic                    illegal;
    logic                    halt;
  } dec_t;

  state_t state;
  state_t state_next;
  dec_t   out_q;
  dec_t   out_d;
  dec_t   decoded;

  logic [INST_WORD_LEN-1:0] word;
  logic [5:0] in_op;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       writes_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_pending;
  logic       hazard;
  logic       hold;

  assign word   = dec.instruction_in;
  assign in_op  = word[31:26];
  assign in_rd  = word[25:21];
  assign in_rs1 = word[20:16];
  assign in_rs2 = word[15:11];

  // Classify the incoming opcode and build the bundle a normal load would issue.
  always_comb begin
    writes_rd         = 1'b0;
    uses_rs1          = 1'b0;
    uses_rs2          = 1'b0;
    decoded           = '0;
    decoded.valid     = 1'b1;
    decoded.opcode    = in_op;
    decoded.rd        = in_rd;
    decoded.rs1       = in_rs1;
    decoded.rs2       = in_rs2;
    decoded.imm       = MEM_ADDR_LEN'(word[15:0]);
    decoded.pc        = dec.pc_in;
    case (in_op)
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_MUL, OP_MAC: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_LD: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OP_ST: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JMP: begin
        decoded.is_branch = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        decoded.is_branch = 1'b1;
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
      end
      OP_HALT: begin
        decoded.halt = 1'b1;
      end
      default: begin
        decoded.illegal = 1'b1;
      end
    endcase
    decoded.reg_write = writes_rd && (in_rd != 5'd0);
  end

  // A load-use hazard: the issued LD writes a register the next instruction reads.
  always_comb begin
    load_pending = out_q.valid && (out_q.opcode == OP_LD) && (out_q.rd != 5'd0);
    hazard       = load_pending &&
                   ((uses_rs1 && (in_rs1 == out_q.rd)) ||
                    (uses_rs2 && (in_rs2 == out_q.rd)));
  end

  // Next state and next output bundle; flush beats stall, stall beats hazard.
  always_comb begin
    state_next = state;
    out_d      = out_q;
    case (state)
      RUN: begin
        if (dec.flush) begin
          out_d      = '0;
          state_next = RUN;
        end else if (dec.stall_in) begin
          out_d      = out_q;
        end else if (hazard) begin
          out_d      = '0;
          state_next = HAZARD;
        end else begin
          out_d      = decoded;
          state_next = decoded.halt ? HALTED : RUN;
        end
      end
      HAZARD: begin
        if (dec.flush) begin
          out_d      = '0;
          state_next = RUN;
        end else if (dec.stall_in) begin
          out_d      = out_q;
        end else begin
          out_d      = decoded;
          state_next = decoded.halt ? HALTED : RUN;
        end
      end
      HALTED: begin
        out_d      = '0;
        state_next = HALTED;
      end
      default: begin
        out_d      = '0;
        state_next = RUN;
      end
    endcase
  end

  // Fetch must keep its PC while execute stalls, a bubble is being inserted, or we are halted.
  always_comb begin
    hold = 1'b0;
    if (rst && !dec.flush) begin
      hold = dec.stall_in || (hazard && (state == RUN)) || (state == HALTED);
    end
  end

  // State register; reset always lands in RUN, dropping any pending bubble or halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Output register holding the issued instruction or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign dec.hold_out      = hold;
  assign dec.valid_out     = out_q.valid;
  assign dec.opcode_out    = out_q.opcode;
  assign dec.rd_out        = out_q.rd;
  assign dec.rs1_out       = out_q.rs1;
  assign dec.rs2_out       = out_q.rs2;
  assign dec.imm_out       = out_q.imm;
  assign dec.pc_out        = out_q.pc;
  assign dec.reg_write_out = out_q.reg_write;
  assign dec.is_branch_out = out_q.is_branch;
  assign dec.illegal_out   = out_q.illegal;
  assign dec.halt_out      = out_q.halt;

endmodule

// File: tb/tb_dsp_decode.sv
// Bench for dsp_decode: directed instruction stream, an instruction-level
// reference model, a per-cycle compare process and literal spot checks.
module tb_dsp_decode;

  localparam int IW = 32;
  localparam int AW = 16;

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [AW-1:0] imm;
    logic [AW-1:0] pc;
    logic          rw;
    logic          br;
    logic          ill;
    logic          halt;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dsp_decode_if #(.INST_WORD_LEN(IW), .MEM_ADDR_LEN(AW)) bus ();

  dsp_decode #(.INST_WORD_LEN(IW), .MEM_ADDR_LEN(AW)) dut (
    .clk (clk),
    .rst (rst),
    .dec (bus)
  );

  out_t dut_out;
  assign dut_out = {bus.valid_out, bus.opcode_out, bus.rd_out, bus.rs1_out,
                    bus.rs2_out, bus.imm_out, bus.pc_out, bus.reg_write_out,
                    bus.is_branch_out, bus.illegal_out, bus.halt_out};

  function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rd,
                                      logic [4:0] rs1, logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // What a legally issued instruction looks like, straight from the opcode table.
  function automatic out_t model_decode(logic [31:0] w, logic [AW-1:0] pc);
    out_t r;
    logic [5:0] op;
    op      = w[31:26];
    r.valid = 1'b1;
    r.op    = op;
    r.rd    = w[25:21];
    r.rs1   = w[20:16];
    r.rs2   = w[15:11];
    r.imm   = w[15:0];
    r.pc    = pc;
    r.rw    = (op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h08}) && (w[25:21] != 5'd0);
    r.br    = op inside {6'h10, 6'h11, 6'h12};
    r.ill   = !(op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09,
                           6'h10, 6'h11, 6'h12, 6'h3F});
    r.halt  = (op == 6'h3F);
    return r;
  endfunction

  function automatic bit reads_reg(logic [31:0] w, logic [4:0] r);
    logic [5:0] op;
    bit s1, s2;
    op = w[31:26];
    s1 = op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h11, 6'h12};
    s2 = op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h09, 6'h11, 6'h12};
    return (s1 && (w[20:16] == r)) || (s2 && (w[15:11] == r));
  endfunction

  function automatic bit load_use(out_t prev, logic [31:0] w);
    return prev.valid && (prev.op == 6'h08) && (prev.rd != 5'd0) && reads_reg(w, prev.rd);
  endfunction

  // Reference model: the instruction on the output register, advanced once per edge.
  out_t exp_out   = '0;
  bit   m_halted  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_out  = '0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      exp_out = '0;
    end else if (bus.flush) begin
      exp_out = '0;
    end else if (bus.stall_in) begin
      exp_out = exp_out;
    end else if (load_use(exp_out, bus.instruction_in)) begin
      exp_out = '0;
    end else begin
      exp_out  = model_decode(bus.instruction_in, bus.pc_in);
      m_halted = exp_out.halt;
    end
  end

  // Every cycle, mid-period, compare the whole output bundle and hold_out.
  always @(negedge clk) begin
    logic exp_hold;
    exp_hold = rst && !bus.flush &&
               (bus.stall_in || load_use(exp_out, bus.instruction_in) || m_halted);
    n_checks++;
    if (dut_out !== exp_out) begin
      n_fail++;
      $display("[TB] FAIL bundle t=%0t got=%h want=%h", $time, dut_out, exp_out);
    end
    n_checks++;
    if (bus.hold_out !== exp_hold) begin
      n_fail++;
      $display("[TB] FAIL hold t=%0t got=%b want=%b", $time, bus.hold_out, exp_hold);
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  task automatic drive(logic [31:0] w, logic [AW-1:0] pc, logic fl, logic st);
    bus.instruction_in = w;
    bus.pc_in          = pc;
    bus.flush          = fl;
    bus.stall_in       = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic [31:0] w, logic [AW-1:0] pc, logic fl, logic st);
    drive(w, pc, fl, st);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    drive(32'h0, 16'h0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #3;
    checkOutput("rst_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("rst_hold", 32'(bus.hold_out), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    drive(enc(6'h01, 5'd3, 5'd1, 16'h1000), 16'h0000, 1'b0, 1'b0);
    tick();
    checkOutput("add_valid", 32'(bus.valid_out), 32'd1);
    checkOutput("add_op", 32'(bus.opcode_out), 32'h01);
    checkOutput("add_rd", 32'(bus.rd_out), 32'd3);
    checkOutput("add_rs1", 32'(bus.rs1_out), 32'd1);
    checkOutput("add_rs2", 32'(bus.rs2_out), 32'd2);
    checkOutput("add_rw", 32'(bus.reg_write_out), 32'd1);
    checkOutput("add_pc", 32'(bus.pc_out), 32'd0);
    checkOutput("model_add_rd", 32'(exp_out.rd), 32'd3);

    applyStimulus(enc(6'h08, 5'd5, 5'd1, 16'h0004), 16'h0001, 1'b0, 1'b0);
    checkOutput("ld_rw", 32'(bus.reg_write_out), 32'd1);
    drive(enc(6'h01, 5'd6, 5'd5, 16'h0000), 16'h0002, 1'b0, 1'b0);
    #1;
    checkOutput("lu_hold", 32'(bus.hold_out), 32'd1);
    tick();
    checkOutput("lu_bubble", 32'(bus.valid_out), 32'd0);
    checkOutput("lu_hold_clear", 32'(bus.hold_out), 32'd0);
    tick();
    checkOutput("lu_add_rd", 32'(bus.rd_out), 32'd6);
    checkOutput("lu_add_pc", 32'(bus.pc_out), 32'd2);

    applyStimulus(enc(6'h08, 5'd0, 5'd1, 16'h0004), 16'h0003, 1'b0, 1'b0);
    checkOutput("ld_r0_rw", 32'(bus.reg_write_out), 32'd0);
    drive(enc(6'h01, 5'd6, 5'd0, 16'h0000), 16'h0004, 1'b0, 1'b0);
    #1;
    checkOutput("r0_no_hold", 32'(bus.hold_out), 32'd0);
    tick();
    checkOutput("r0_add_valid", 32'(bus.valid_out), 32'd1);

    applyStimulus(enc(6'h08, 5'd7, 5'd2, 16'h0000), 16'h0005, 1'b0, 1'b0);
    applyStimulus(enc(6'h09, 5'd0, 5'd2, 16'h3800), 16'h0006, 1'b0, 1'b0);
    checkOutput("st_bubble", 32'(bus.valid_out), 32'd0);
    applyStimulus(enc(6'h09, 5'd0, 5'd2, 16'h3800), 16'h0006, 1'b0, 1'b1);
    applyStimulus(enc(6'h09, 5'd0, 5'd2, 16'h3800), 16'h0006, 1'b0, 1'b0);
    checkOutput("st_pc", 32'(bus.pc_out), 32'd6);
    applyStimulus(enc(6'h08, 5'd9, 5'd1, 16'h0000), 16'h0007, 1'b0, 1'b0);
    applyStimulus(enc(6'h10, 5'd0, 5'd9, 16'h0040), 16'h0008, 1'b0, 1'b0);
    checkOutput("jmp_branch", 32'(bus.is_branch_out), 32'd1);

    applyStimulus(enc(6'h11, 5'd0, 5'd1, 16'h1003), 16'h0004, 1'b0, 1'b0);
    checkOutput("beq_branch", 32'(bus.is_branch_out), 32'd1);
    drive(enc(6'h02, 5'd4, 5'd1, 16'h1000), 16'h0005, 1'b1, 1'b0);
    #1;
    checkOutput("flush_hold", 32'(bus.hold_out), 32'd0);
    tick();
    checkOutput("flush_bubble", 32'(bus.valid_out), 32'd0);
    applyStimulus(enc(6'h03, 5'd7, 5'd1, 16'h1000), 16'h0020, 1'b0, 1'b0);
    checkOutput("target_pc", 32'(bus.pc_out), 32'h20);

    applyStimulus(enc(6'h01, 5'd2, 5'd3, 16'h2000), 16'h0021, 1'b0, 1'b0);
    drive(enc(6'h02, 5'd8, 5'd2, 16'h1800), 16'h0022, 1'b0, 1'b1);
    #1;
    checkOutput("stall_hold", 32'(bus.hold_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_frozen", 32'(bus.pc_out), 32'h21);
    end
    applyStimulus(enc(6'h02, 5'd8, 5'd2, 16'h1800), 16'h0022, 1'b0, 1'b0);
    checkOutput("stall_next", 32'(bus.pc_out), 32'h22);
    applyStimulus(enc(6'h04, 5'd1, 5'd2, 16'h1800), 16'h0023, 1'b0, 1'b0);
    checkOutput("mac_pc", 32'(bus.pc_out), 32'h23);

    applyStimulus(enc(6'h3E, 5'd5, 5'd1, 16'h0000), 16'h0024, 1'b0, 1'b0);
    checkOutput("ill_valid", 32'(bus.valid_out), 32'd1);
    checkOutput("ill_flag", 32'(bus.illegal_out), 32'd1);
    checkOutput("ill_rw", 32'(bus.reg_write_out), 32'd0);

    applyStimulus(enc(6'h3F, 5'd0, 5'd0, 16'h0000), 16'h0025, 1'b0, 1'b0);
    checkOutput("halt_flag", 32'(bus.halt_out), 32'd1);
    drive(enc(6'h00, 5'd0, 5'd0, 16'h0000), 16'h0026, 1'b0, 1'b0);
    #1;
    checkOutput("halted_hold", 32'(bus.hold_out), 32'd1);
    tick();
    checkOutput("halted_bubble", 32'(bus.valid_out), 32'd0);
    checkOutput("halted_halt_once", 32'(bus.halt_out), 32'd0);
    applyStimulus(enc(6'h01, 5'd3, 5'd1, 16'h1000), 16'h0027, 1'b1, 1'b0);
    checkOutput("halted_flush_ignored", 32'(bus.valid_out), 32'd0);
    drive(enc(6'h01, 5'd3, 5'd1, 16'h1000), 16'h0027, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("halted_stays", 32'(bus.hold_out), 32'd1);

    rst = 1'b0;
    #1;
    checkOutput("halt_rst_hold", 32'(bus.hold_out), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(enc(6'h01, 5'd3, 5'd1, 16'h1000), 16'h0030, 1'b0, 1'b0);
    checkOutput("post_halt_pc", 32'(bus.pc_out), 32'h30);

    applyStimulus(enc(6'h08, 5'd5, 5'd1, 16'h0000), 16'h0031, 1'b0, 1'b0);
    applyStimulus(enc(6'h01, 5'd6, 5'd5, 16'h0000), 16'h0032, 1'b0, 1'b0);
    checkOutput("hz_bubble", 32'(bus.valid_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("hz_rst_valid", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    checkOutput("hz_rst_add_pc", 32'(bus.pc_out), 32'h32);
    checkOutput("hz_rst_add_valid", 32'(bus.valid_out), 32'd1);

    applyStimulus(enc(6'h03, 5'd4, 5'd2, 16'h1800), 16'h0040, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.valid_out), 32'd0);
    checkOutput("async_rst_pc", 32'(bus.pc_out), 32'd0);
    checkOutput("async_rst_op", 32'(bus.opcode_out), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(enc(6'h12, 5'd0, 5'd1, 16'h1000), 16'h0041, 1'b0, 1'b0);
    applyStimulus(enc(6'h00, 5'd0, 5'd0, 16'h0000), 16'h0042, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
